// File: rtl/timer_peripheral.sv
// Memory-mapped reloadable timer with prescaler, sticky overflow interrupt and
// a free-running SYSTICK counter; combinational read port for the MEM stage.
module timer_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  typedef enum logic [2:0] {
    SEL_TH      = 3'd0,
    SEL_TL      = 3'd1,
    SEL_TCON    = 3'd2,
    SEL_PRESC   = 3'd3,
    SEL_SYSTICK = 3'd4,
    SEL_RSVD    = 3'd5
  } reg_sel_e;

  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  logic [31:0]        th;
  logic [31:0]        tl;
  logic [31:0]        systick;
  logic               en;
  logic               ie;
  logic               st;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;

  logic [31:0] offset;
  logic        hit;
  reg_sel_e    sel;
  logic        wr_th, wr_tl, wr_tcon, wr_presc;
  logic        tick, at_max, ovf, set_st;

  // Window is six words; byte lane bits are part of the range check only.
  assign offset = addr - BASE_ADDR;
  assign hit    = offset < 32'd24;
  assign sel    = reg_sel_e'(offset[4:2]);

  assign wr_th    = wr & hit & (sel == SEL_TH);
  assign wr_tl    = wr & hit & (sel == SEL_TL);
  assign wr_tcon  = wr & hit & (sel == SEL_TCON);
  assign wr_presc = wr & hit & (sel == SEL_PRESC);

  assign tick   = en & (pcnt == presc);
  assign at_max = (tl == '1);
  // A software TL write pre-empts the overflow entirely; a TCON write that
  // enables IE on the overflow edge still lets the hardware set win.
  assign ovf    = tick & at_max & ~wr_tl;
  assign set_st = ovf & (ie | (wr_tcon & wdata[1]));

  assign irqout = ie & st;

  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      case (sel)
        SEL_TH:      rdata = th;
        SEL_TL:      rdata = tl;
        SEL_TCON:    rdata = {29'b0, st, ie, en};
        SEL_PRESC:   rdata = 32'(presc);
        SEL_SYSTICK: rdata = systick;
        default:     rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      systick <= '0;
      en      <= 1'b0;
      ie      <= 1'b0;
      st      <= 1'b0;
      presc   <= '0;
      pcnt    <= '0;
    end else begin
      systick <= systick + 32'd1;

      if (wr_th) th <= wdata;

      if (wr_tl)     tl <= wdata;
      else if (tick) tl <= at_max ? th : tl + 32'd1;

      if (wr_tcon) begin
        en <= wdata[0];
        ie <= wdata[1];
      end

      if (set_st)                  st <= 1'b1;
      else if (wr_tcon && !wdata[2]) st <= 1'b0;

      if (wr_presc) presc <= wdata[PRESC_W-1:0];

      if (wr_presc || !en || tick) pcnt <= '0;
      else                         pcnt <= pcnt + PRESC_ONE;
    end
  end

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed and randomized checks of timer_peripheral against a cycle-level
// behavioural model of the register rules.
module tb_timer_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;

  always #5 clk = ~clk;

  timer_peripheral #(
    .BASE_ADDR(BASE),
    .PRESC_W  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .wdata (wdata),
    .rdata (rdata),
    .irqout(irqout)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_th = '0, m_tl = '0, m_sys = '0;
  logic        m_en = 1'b0, m_ie = 1'b0, m_st = 1'b0;
  logic [7:0]  m_presc = '0, m_pcnt = '0;

  logic [31:0] last_rdata;
  logic [31:0] last_irq;

  function automatic int reg_index(input logic [31:0] a);
    if (a < BASE || a > BASE + 32'h17) return -1;
    return int'((a - BASE) / 32'd4);
  endfunction

  function automatic logic [31:0] model_read(input logic r, input logic [31:0] a);
    if (!r) return 32'h0;
    case (reg_index(a))
      0:       return m_th;
      1:       return m_tl;
      2:       return {29'b0, m_st, m_ie, m_en};
      3:       return {24'b0, m_presc};
      4:       return m_sys;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic w, input logic [31:0] a,
                            input logic [31:0] d);
    int   idx;
    logic tk, overflow;
    if (rst) begin
      m_th = 0; m_tl = 0; m_sys = 0; m_en = 0; m_ie = 0; m_st = 0;
      m_presc = 0; m_pcnt = 0;
      return;
    end
    idx      = w ? reg_index(a) : -1;
    tk       = m_en && (m_pcnt == m_presc);
    overflow = tk && (m_tl == 32'hFFFF_FFFF) && (idx != 1);
    m_sys    = m_sys + 1;
    if (idx == 1)  m_tl = d;
    else if (tk)   m_tl = (m_tl == 32'hFFFF_FFFF) ? m_th : m_tl + 1;
    if (overflow && (m_ie || (idx == 2 && d[1]))) m_st = 1'b1;
    else if (idx == 2 && !d[2])                   m_st = 1'b0;
    if (idx == 3 || !m_en || tk) m_pcnt = 0;
    else                         m_pcnt = m_pcnt + 1;
    if (idx == 0) m_th = d;
    if (idx == 2) begin m_en = d[0]; m_ie = d[1]; end
    if (idx == 3) m_presc = d[7:0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    reset = rst; rd = r; wr = w; addr = a; wdata = d;
    @(negedge clk);
    last_rdata = rdata;
    last_irq   = {31'b0, irqout};
    if (!rst) begin
      chk("rdata_model", rdata, model_read(r, a));
      chk("irq_model", {31'b0, irqout}, {31'b0, m_ie & m_st});
    end
    @(posedge clk);
    model_step(rst, w, a, d);
    #1;
  endtask

  task automatic wreg(input int unsigned idx, input logic [31:0] d);
    cyc(1'b0, 1'b0, 1'b1, BASE + 32'(idx * 4), d);
  endtask

  task automatic rreg(input int unsigned idx);
    cyc(1'b0, 1'b1, 1'b0, BASE + 32'(idx * 4), 32'h0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic        r_rst, r_rd, r_wr;
    logic [31:0] r_a, r_d;
    int unsigned r_sel;

    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset values and SYSTICK start
    rreg(4); chk("systick_c0", last_rdata, 32'h0);
    chk("irq_after_reset", last_irq, 32'h0);
    rreg(4); chk("systick_c1", last_rdata, 32'h1);
    for (int unsigned i = 0; i < 4; i++) begin
      rreg(i); chk("reset_reg", last_rdata, 32'h0);
    end
    rreg(5); chk("rsvd_read", last_rdata, 32'h0);
    rreg(4); chk("systick_c7", last_rdata, 32'h7);

    // Overflow with reload and interrupt
    wreg(0, 32'hFFFF_FFF0);
    wreg(1, 32'hFFFF_FFFE);
    wreg(3, 32'h0);
    wreg(2, 32'h3);
    rreg(1); chk("tl_fe", last_rdata, 32'hFFFF_FFFE);
    rreg(1); chk("tl_ff", last_rdata, 32'hFFFF_FFFF);
    chk("irq_before_ovf", last_irq, 32'h0);
    rreg(1); chk("tl_reload", last_rdata, 32'hFFFF_FFF0);
    chk("irq_after_ovf", last_irq, 32'h1);
    rreg(2); chk("tcon_st", last_rdata, 32'h7);
    idle(3);
    chk("irq_sticky", last_irq, 32'h1);

    // Software clear of ST
    wreg(2, 32'h3);
    chk("irq_before_clear", last_irq, 32'h1);
    rreg(2); chk("tcon_cleared", last_rdata, 32'h3);
    chk("irq_cleared", last_irq, 32'h0);
    rreg(1); chk("tl_running", last_rdata, 32'hFFFF_FFF7);

    // Prescaler of 3
    wreg(2, 32'h0);
    wreg(3, 32'h3);
    wreg(1, 32'h0);
    wreg(2, 32'h1);
    for (int unsigned j = 0; j <= 12; j++) begin
      rreg(1); chk("presc_tl", last_rdata, 32'(j / 4));
    end
    rreg(2); chk("presc_no_st", last_rdata, 32'h1);

    // TL write on the overflow edge
    wreg(2, 32'h0);
    wreg(3, 32'h0);
    wreg(0, 32'h0000_A5A5);
    wreg(1, 32'hFFFF_FFFE);
    wreg(2, 32'h3);
    rreg(1); chk("tl_fe2", last_rdata, 32'hFFFF_FFFE);
    wreg(1, 32'h1234_5678);
    rreg(1); chk("tl_write_wins", last_rdata, 32'h1234_5678);
    rreg(2); chk("tl_write_no_st", last_rdata, 32'h3);

    // TCON write on the overflow edge, IE already set
    wreg(1, 32'hFFFF_FFFE);
    idle(1);
    wreg(2, 32'h2);
    rreg(2); chk("tcon_ovf_hw_set", last_rdata, 32'h6);
    chk("irq_tcon_ovf", last_irq, 32'h1);
    rreg(1); chk("tl_reload_a5", last_rdata, 32'h0000_A5A5);
    rreg(1); chk("tl_stopped", last_rdata, 32'h0000_A5A5);

    // TCON write enabling IE on the overflow edge
    wreg(2, 32'h0);
    wreg(1, 32'hFFFF_FFFF);
    wreg(2, 32'h1);
    wreg(2, 32'h3);
    rreg(2); chk("tcon_new_ie_set", last_rdata, 32'h7);
    rreg(1); chk("tl_after_new_ie", last_rdata, 32'h0000_A5A6);

    // TH write on the overflow edge reloads the old TH
    wreg(2, 32'h3);
    wreg(1, 32'hFFFF_FFFF);
    wreg(0, 32'h0000_0777);
    rreg(1); chk("tl_old_th", last_rdata, 32'h0000_A5A5);
    chk("irq_th_ovf", last_irq, 32'h1);
    rreg(0); chk("th_new", last_rdata, 32'h0000_0777);

    // Reset mid-count with irqout high, then ignored writes
    chk("irq_before_reset", last_irq, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    wreg(4, 32'hDEAD_BEEF);
    chk("irq_reset_mid", last_irq, 32'h0);
    chk("rdata_idle_reset", last_rdata, 32'h0);
    wreg(5, 32'hBEEF_CAFE);
    rreg(5); chk("rsvd_ignored", last_rdata, 32'h0);
    rreg(4); chk("systick_ignored", last_rdata, 32'h3);
    for (int unsigned i = 0; i < 4; i++) begin
      rreg(i); chk("reg_after_reset", last_rdata, 32'h0);
    end

    // Randomized traffic against the model
    for (int unsigned n = 0; n < 4000; n++) begin
      r_rst = ($urandom_range(0, 399) == 0);
      r_rd  = $urandom_range(0, 1) == 1;
      r_wr  = $urandom_range(0, 2) == 0;
      r_sel = $urandom_range(0, 7);
      r_a   = BASE + 32'(r_sel * 4) + 32'($urandom_range(0, 3));
      case ($urandom_range(0, 19))
        0:       r_a = $urandom();
        1:       r_a = BASE - 32'd4 + 32'($urandom_range(0, 3));
        default: ;
      endcase
      r_d = $urandom();
      if (r_sel == 1 && $urandom_range(0, 1) == 1)
        r_d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if (r_sel == 3)
        r_d = (r_d & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
      if (r_sel == 2 && $urandom_range(0, 3) != 0)
        r_d = r_d | 32'h1;
      cyc(r_rst, r_rd, r_wr, r_a, r_d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
